sram_host_port_ctrl: RTL and testbench
======================================

Name: sram_host_port_ctrl

Overview:
Host-side initiator for the 2-port (1RW + 1R) SRAM macro: converts valid/ready request channels into macro pin activity and returns read data on valid/ready response channels.
- Channel A maps to port 0 (RW); channel B maps to port 1 (R).
- The block clocks the macro from its own clock and owns all pipeline timing, read-data capture, flow control and the port0-write/port1-read same-address collision rule.

Parameters:
DATA_WIDTH, 16, data word width
ADDR_WIDTH, 4, word address width (depth = 1<<ADDR_WIDTH)
NUM_WMASKS, 2, byte write-mask bits (DATA_WIDTH/8)
RSP_DEPTH, 4, per-channel response buffer entries (power of two, >=3 for full throughput)

Ports:
- clk  in  1  single clock; also drives macro clk0/clk1
- rst  in  1  asynchronous active-high reset
- a_req_valid  in  1;  a_req_ready  out  1;  a_req_we  in  1 (1=write);  a_req_wmask  in  NUM_WMASKS;  a_req_addr  in  ADDR_WIDTH;  a_req_wdata  in  DATA_WIDTH
- a_rsp_valid  out  1;  a_rsp_ready  in  1;  a_rsp_rdata  out  DATA_WIDTH
- b_req_valid  in  1;  b_req_ready  out  1;  b_req_addr  in  ADDR_WIDTH
- b_rsp_valid  out  1;  b_rsp_ready  in  1;  b_rsp_rdata  out  DATA_WIDTH
- csb0, web0  out  1;  wmask0  out  NUM_WMASKS;  addr0  out  ADDR_WIDTH;  din0  out  DATA_WIDTH;  dout0  in  DATA_WIDTH
- csb1  out  1;  addr1  out  ADDR_WIDTH;  dout1  in  DATA_WIDTH

Behaviour:
- Reset values:
  - csb0 = csb1 = web0 = 1; wmask0, addr0, din0, addr1 = 0.
  - a/b_rsp_valid = 0; all buffers empty; all pipeline valid bits 0; credit counters = RSP_DEPTH.
- Macro pins are flops only, updated on posedge clk. An idle cycle drives csb = 1; web0/wmask0/addr0/din0 hold their last values.
- Accepting a request (valid && ready at posedge T) loads the pins at T. The macro samples them at T+1.
- Write (a_req_we=1):
  - Drives csb0=0, web0=0, wmask0, din0.
  - Writes produce no response and consume no credit.
  - A write with wmask=0 is still issued.
- Read, timing:
  - Drives csb=0 (port 0 also web0=1).
  - Stage valid bits are set at T and shifted to T+1.
  - dout is captured into the channel's response buffer at posedge T+2, so rsp_valid is high after T+2.
  - Request-to-response latency = 2 cycles when the buffer is empty.
  - dout is never sampled unless the stage-2 valid bit is set, because the macro drives X otherwise.
- Read, credits:
  - Each channel has a credit counter = RSP_DEPTH − (reads in flight + buffered entries).
  - A read acceptance decrements it; a response pop (rsp_valid && rsp_ready) increments it; both in one cycle leave it unchanged.
  - a_req_ready = (credit>0) || a_req_we.
  - b_req_ready = (credit>0) && !collision.
  - The buffer therefore never overflows; responses are returned in order.
  - With rsp_ready held 1, the channel sustains one read per cycle.
- Collision rule:
  - A collision is a write being accepted on A and a read on B in the same cycle with a_req_addr == b_req_addr.
  - Channel A wins. b_req_ready=0 that cycle and B issues the next cycle, returning the newly written data.
- Read from B of an address written by A on any earlier accepted cycle returns the new data. Same for A reading after its own write, back-to-back.
- Response outputs are driven straight from the buffer head (first-word fall-through); rsp_rdata is stable while rsp_valid && !rsp_ready.
- Reset mid-operation:
  - In-flight reads are discarded and buffers are flushed; no response is produced for them.
  - Pins return to reset values asynchronously.
  - Macro contents are not touched by the block.
- Widths: credit counters are clog2(RSP_DEPTH)+1 bits; buffer pointers wrap modulo RSP_DEPTH.

Decomposition:
- Package sram_host_pkg:
  - DATA_WIDTH/ADDR_WIDTH/NUM_WMASKS defaults.
  - Request struct typedef (we, wmask, addr, wdata).
  - Stage-valid typedef.
  - Function computing collision.
- Sub-module sram_rsp_fifo: parameterised FWFT FIFO (DEPTH, WIDTH) with push/pop/count and credit output. Instantiated once per channel.

Test Plan:
1. Write A addr 3 data 0xA5C3 wmask 2'b11, then read A addr 3 -> a_rsp_rdata=0xA5C3 exactly 2 cycles after read accept.
2. Preload addr 7=0xFFFF; write 0x1234 wmask 2'b01; read via B -> b_rsp_rdata=0xFF34; wmask 2'b10 write of 0xABCD then read -> 0xAB34.
3. Write addrs 0..15 with data addr*0x1111, then 16 back-to-back A reads with rsp_ready=1 -> 16 consecutive rsp_valid cycles, data in address order, req_ready never low.
4. Hold a_rsp_ready=0, offer 6 reads -> exactly 4 accepted, a_req_ready=0 after; release ready -> 4 responses in order, then remaining 2 accepted.
5. Same cycle: A write addr 5 = 0x0BAD, B read addr 5 -> b_req_ready=0 that cycle; B issues next cycle, b_rsp_rdata=0x0BAD; different addresses -> both accepted, no stall.
6. Assert rst with 2 reads in flight and 1 buffered -> csb0=csb1=1 immediately, rsp_valid=0, no stale responses after release, full credits restored.

Source files
------------

// File: rtl/sram_host_pkg.sv
// Shared types and helpers for the SRAM host-port controller.
package sram_host_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_NUM_WMASKS = 2;
    localparam int DEF_RSP_DEPTH  = 4;

    // One host request as presented on channel A (B only uses addr).
    typedef struct packed {
        logic                      we;
        logic [DEF_NUM_WMASKS-1:0] wmask;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } sram_req_t;

    // Read pipeline occupancy: s1 = pins loaded, s2 = macro sampled, data due next edge.
    typedef struct packed {
        logic s2;
        logic s1;
    } stage_vld_t;

    // What a macro port is asked to do in the coming cycle.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } port_op_e;

    // A write accepted on A and a read on B that target the same word.
    // A wins so that B's read lands one cycle later and sees the new data.
    function automatic logic collides(input logic                      aWriteFire,
                                      input logic [DEF_ADDR_WIDTH-1:0] aAddr,
                                      input logic [DEF_ADDR_WIDTH-1:0] bAddr);
        return aWriteFire && (aAddr == bAddr);
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// First-word-fall-through response buffer with read-credit accounting.
// Credits are reserved when a read is issued, so a push can never find it full.
module sram_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reserve_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] credit_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] credit_q, credit_d;
    logic             popFire;

    assign popFire  = pop_i && (count_q != '0);
    assign valid_o  = (count_q != '0);
    assign data_o   = mem_q[rdPtr_q];
    assign count_o  = count_q;
    assign credit_o = credit_q;

    // Next pointers, occupancy and credits; pointers wrap naturally at DEPTH.
    always_comb begin
        wrPtr_d  = wrPtr_q + PTR_W'(push_i);
        rdPtr_d  = rdPtr_q + PTR_W'(popFire);
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(popFire);
        credit_d = credit_q - CNT_W'(reserve_i) + CNT_W'(popFire);
    end

    // Control state; reset flushes the buffer and returns every credit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            credit_q <= CNT_W'(DEPTH);
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            credit_q <= credit_d;
        end
    end

    // Storage needs no reset: an entry is only visible once counted.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wrPtr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/sram_host_port_ctrl.sv
// Host-side initiator for a 1RW + 1R SRAM macro. Channel A drives port 0,
// channel B drives port 1. Pins are registered; read data is captured two
// edges after acceptance into a per-channel FWFT response buffer.
module sram_host_port_ctrl
    import sram_host_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_WMASKS = DEF_NUM_WMASKS,
    parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [NUM_WMASKS-1:0] a_req_wmask,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_rsp_valid,
    input  logic                  a_rsp_ready,
    output logic [DATA_WIDTH-1:0] a_rsp_rdata,

    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    output logic                  b_rsp_valid,
    input  logic                  b_rsp_ready,
    output logic [DATA_WIDTH-1:0] b_rsp_rdata,

    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,

    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
);

    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

    sram_req_t              aReq;
    logic                   aFire, aReadFire, aWriteFire;
    logic                   bFire;
    logic [CNT_W-1:0]       aCredit, bCredit;
    logic [CNT_W-1:0]       aCount, bCount;
    port_op_e               op0, op1;
    stage_vld_t             aStage_q, aStage_d;
    stage_vld_t             bStage_q, bStage_d;

    logic                   csb0_q, csb0_d;
    logic                   web0_q, web0_d;
    logic [NUM_WMASKS-1:0]  wmask0_q, wmask0_d;
    logic [ADDR_WIDTH-1:0]  addr0_q, addr0_d;
    logic [DATA_WIDTH-1:0]  din0_q, din0_d;
    logic                   csb1_q, csb1_d;
    logic [ADDR_WIDTH-1:0]  addr1_q, addr1_d;

    assign aReq = '{we: a_req_we, wmask: a_req_wmask, addr: a_req_addr, wdata: a_req_wdata};

    // Writes need no buffer slot, so they are never throttled by credits.
    assign a_req_ready = (aCredit != '0) || a_req_we;
    assign aFire       = a_req_valid && a_req_ready;
    assign aWriteFire  = aFire && aReq.we;
    assign aReadFire   = aFire && !aReq.we;

    // B backs off for one cycle when A is writing the word B wants to read.
    assign b_req_ready = (bCredit != '0) && !collides(aWriteFire, a_req_addr, b_req_addr);
    assign bFire       = b_req_valid && b_req_ready;

    // Decode what each macro port does in the next cycle.
    always_comb begin
        op0 = OP_IDLE;
        op1 = OP_IDLE;
        if (aFire) begin
            op0 = aReq.we ? OP_WRITE : OP_READ;
        end
        if (bFire) begin
            op1 = OP_READ;
        end
    end

    // Pin next-state: idle deselects, other port-0 pins keep their last value.
    always_comb begin
        csb0_d   = 1'b1;
        web0_d   = web0_q;
        wmask0_d = wmask0_q;
        addr0_d  = addr0_q;
        din0_d   = din0_q;
        csb1_d   = 1'b1;
        addr1_d  = addr1_q;
        unique case (op0)
            OP_WRITE: begin
                csb0_d   = 1'b0;
                web0_d   = 1'b0;
                wmask0_d = aReq.wmask;
                addr0_d  = aReq.addr;
                din0_d   = aReq.wdata;
            end
            OP_READ: begin
                csb0_d   = 1'b0;
                web0_d   = 1'b1;
                addr0_d  = aReq.addr;
            end
            default: begin
            end
        endcase
        if (op1 == OP_READ) begin
            csb1_d  = 1'b0;
            addr1_d = b_req_addr;
        end
    end

    // Macro pins are pure flops and fall back to the deselected state on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csb0_q   <= 1'b1;
            web0_q   <= 1'b1;
            wmask0_q <= '0;
            addr0_q  <= '0;
            din0_q   <= '0;
            csb1_q   <= 1'b1;
            addr1_q  <= '0;
        end else begin
            csb0_q   <= csb0_d;
            web0_q   <= web0_d;
            wmask0_q <= wmask0_d;
            addr0_q  <= addr0_d;
            din0_q   <= din0_d;
            csb1_q   <= csb1_d;
            addr1_q  <= addr1_d;
        end
    end

    assign csb0   = csb0_q;
    assign web0   = web0_q;
    assign wmask0 = wmask0_q;
    assign addr0  = addr0_q;
    assign din0   = din0_q;
    assign csb1   = csb1_q;
    assign addr1  = addr1_q;

    // Read pipeline shift: s1 when pins load, s2 when the macro samples.
    always_comb begin
        aStage_d = '{s2: aStage_q.s1, s1: aReadFire};
        bStage_d = '{s2: bStage_q.s1, s1: bFire};
    end

    // Pipeline valid bits; reset drops any read already in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aStage_q <= '0;
            bStage_q <= '0;
        end else begin
            aStage_q <= aStage_d;
            bStage_q <= bStage_d;
        end
    end

    // dout is only meaningful when s2 is set, so it is only pushed then.
    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_a (
        .clk         (clk),
        .rst         (rst),
        .reserve_i   (aReadFire),
        .push_i      (aStage_q.s2),
        .push_data_i (dout0),
        .pop_i       (a_rsp_valid && a_rsp_ready),
        .valid_o     (a_rsp_valid),
        .data_o      (a_rsp_rdata),
        .count_o     (aCount),
        .credit_o    (aCredit)
    );

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_b (
        .clk         (clk),
        .rst         (rst),
        .reserve_i   (bFire),
        .push_i      (bStage_q.s2),
        .push_data_i (dout1),
        .pop_i       (b_rsp_valid && b_rsp_ready),
        .valid_o     (b_rsp_valid),
        .data_o      (b_rsp_rdata),
        .count_o     (bCount),
        .credit_o    (bCredit)
    );

    // Credits, in-flight reads and buffered words always add up to RSP_DEPTH.
    assert property (@(posedge clk) disable iff (rst)
        (aCredit + aCount + CNT_W'(aStage_q.s1) + CNT_W'(aStage_q.s2)) == CNT_W'(RSP_DEPTH));
    assert property (@(posedge clk) disable iff (rst)
        (bCredit + bCount + CNT_W'(bStage_q.s1) + CNT_W'(bStage_q.s2)) == CNT_W'(RSP_DEPTH));

endmodule

// File: tb/tb_sram_host_port_ctrl.sv
// Directed bench for sram_host_port_ctrl with a behavioural 1RW+1R macro.
module tb_sram_host_port_ctrl;

    logic        clk;
    logic        rst;
    logic        a_req_valid, a_req_ready, a_req_we;
    logic [1:0]  a_req_wmask;
    logic [3:0]  a_req_addr;
    logic [15:0] a_req_wdata;
    logic        a_rsp_valid, a_rsp_ready;
    logic [15:0] a_rsp_rdata;
    logic        b_req_valid, b_req_ready;
    logic [3:0]  b_req_addr;
    logic        b_rsp_valid, b_rsp_ready;
    logic [15:0] b_rsp_rdata;
    logic        csb0, web0, csb1;
    logic [1:0]  wmask0;
    logic [3:0]  addr0, addr1;
    logic [15:0] din0, dout0, dout1;

    int total;
    int bad;

    typedef enum logic [1:0] {V_WRA, V_RDA, V_RDB} vop_e;
    typedef struct {
        vop_e        op;
        logic [3:0]  addr;
        logic [1:0]  wmask;
        logic [15:0] wdata;
        logic [15:0] expData;
    } vec_t;

    vec_t vecs [13];

    sram_host_port_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .a_req_valid (a_req_valid),
        .a_req_ready (a_req_ready),
        .a_req_we    (a_req_we),
        .a_req_wmask (a_req_wmask),
        .a_req_addr  (a_req_addr),
        .a_req_wdata (a_req_wdata),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_ready (a_rsp_ready),
        .a_rsp_rdata (a_rsp_rdata),
        .b_req_valid (b_req_valid),
        .b_req_ready (b_req_ready),
        .b_req_addr  (b_req_addr),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_ready (b_rsp_ready),
        .b_rsp_rdata (b_rsp_rdata),
        .csb0        (csb0),
        .web0        (web0),
        .wmask0      (wmask0),
        .addr0       (addr0),
        .din0        (din0),
        .dout0       (dout0),
        .csb1        (csb1),
        .addr1       (addr1),
        .dout1       (dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural macro: samples pins at posedge, drives X when not reading.
    logic [15:0] macroMem [16];
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 2; b++) begin
                    if (wmask0[b]) macroMem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
                end
                dout0 <= 'x;
            end else begin
                dout0 <= macroMem[addr0];
            end
        end else begin
            dout0 <= 'x;
        end
        if (!csb1) dout1 <= macroMem[addr1];
        else       dout1 <= 'x;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called at posedge+1 right after the accept edge; expects data two edges later.
    task automatic waitRsp(input logic isB, input logic [15:0] expData, input string name);
        int          lat;
        logic        seen;
        logic [15:0] got;
        lat  = 0;
        seen = 1'b0;
        got  = '0;
        for (int k = 0; k < 8; k++) begin
            if (!seen) begin
                @(posedge clk); #1;
                lat++;
                @(negedge clk);
                if (isB ? b_rsp_valid : a_rsp_valid) begin
                    seen = 1'b1;
                    got  = isB ? b_rsp_rdata : a_rsp_rdata;
                end
            end
        end
        @(posedge clk); #1;
        checkOutput({name, " latency"}, seen ? 32'(lat) : 32'd99, 32'd2);
        checkOutput({name, " data"}, {16'h0, got}, {16'h0, expData});
    endtask

    // One table vector: offer it, check the pins it produces, then its response.
    task automatic applyStimulus(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        case (v.op)
            V_WRA: begin
                a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = v.addr;
                a_req_wmask = v.wmask; a_req_wdata = v.wdata;
                @(negedge clk);
                checkOutput({tag, " a_req_ready"}, 32'(a_req_ready), 32'd1);
                @(posedge clk); #1;
                a_req_valid = 1'b0; a_req_we = 1'b0;
                checkOutput({tag, " csb0"}, 32'(csb0), 32'd0);
                checkOutput({tag, " web0"}, 32'(web0), 32'd0);
                checkOutput({tag, " addr0"}, 32'(addr0), 32'(v.addr));
                checkOutput({tag, " din0"}, 32'(din0), 32'(v.wdata));
                checkOutput({tag, " wmask0"}, 32'(wmask0), 32'(v.wmask));
                @(posedge clk); #1;
                checkOutput({tag, " idle csb0"}, 32'(csb0), 32'd1);
                checkOutput({tag, " idle din0 hold"}, 32'(din0), 32'(v.wdata));
            end
            V_RDA: begin
                a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = v.addr;
                @(negedge clk);
                checkOutput({tag, " a_req_ready"}, 32'(a_req_ready), 32'd1);
                @(posedge clk); #1;
                a_req_valid = 1'b0;
                checkOutput({tag, " csb0"}, 32'(csb0), 32'd0);
                checkOutput({tag, " web0"}, 32'(web0), 32'd1);
                checkOutput({tag, " addr0"}, 32'(addr0), 32'(v.addr));
                waitRsp(1'b0, v.expData, {tag, " rspA"});
            end
            default: begin
                b_req_valid = 1'b1; b_req_addr = v.addr;
                @(negedge clk);
                checkOutput({tag, " b_req_ready"}, 32'(b_req_ready), 32'd1);
                @(posedge clk); #1;
                b_req_valid = 1'b0;
                checkOutput({tag, " csb1"}, 32'(csb1), 32'd0);
                checkOutput({tag, " addr1"}, 32'(addr1), 32'(v.addr));
                waitRsp(1'b1, v.expData, {tag, " rspB"});
            end
        endcase
    endtask

    int   acc, rx, notReady, early, stale, accA, accB;
    logic gap;
    logic [15:0] holdData;

    initial begin
        total = 0; bad = 0;
        vecs[0]  = '{V_WRA, 4'd3,  2'b11, 16'hA5C3, 16'h0000};
        vecs[1]  = '{V_RDA, 4'd3,  2'b00, 16'h0000, 16'hA5C3};
        vecs[2]  = '{V_WRA, 4'd7,  2'b11, 16'hFFFF, 16'h0000};
        vecs[3]  = '{V_WRA, 4'd7,  2'b01, 16'h1234, 16'h0000};
        vecs[4]  = '{V_RDB, 4'd7,  2'b00, 16'h0000, 16'hFF34};
        vecs[5]  = '{V_WRA, 4'd7,  2'b10, 16'hABCD, 16'h0000};
        vecs[6]  = '{V_RDB, 4'd7,  2'b00, 16'h0000, 16'hAB34};
        vecs[7]  = '{V_RDA, 4'd7,  2'b00, 16'h0000, 16'hAB34};
        vecs[8]  = '{V_WRA, 4'd9,  2'b11, 16'h1357, 16'h0000};
        vecs[9]  = '{V_WRA, 4'd9,  2'b00, 16'hFFFF, 16'h0000};
        vecs[10] = '{V_RDB, 4'd9,  2'b00, 16'h0000, 16'h1357};
        vecs[11] = '{V_WRA, 4'd15, 2'b11, 16'hBEEF, 16'h0000};
        vecs[12] = '{V_RDA, 4'd15, 2'b00, 16'h0000, 16'hBEEF};

        rst = 1'b1;
        a_req_valid = 0; a_req_we = 0; a_req_wmask = 0; a_req_addr = 0; a_req_wdata = 0;
        b_req_valid = 0; b_req_addr = 0;
        a_rsp_ready = 1; b_rsp_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset csb0", 32'(csb0), 32'd1);
        checkOutput("reset csb1", 32'(csb1), 32'd1);
        checkOutput("reset web0", 32'(web0), 32'd1);
        checkOutput("reset wmask0", 32'(wmask0), 32'd0);
        checkOutput("reset addr0", 32'(addr0), 32'd0);
        checkOutput("reset din0", 32'(din0), 32'd0);
        checkOutput("reset addr1", 32'(addr1), 32'd0);
        checkOutput("reset a_rsp_valid", 32'(a_rsp_valid), 32'd0);
        checkOutput("reset b_rsp_valid", 32'(b_rsp_valid), 32'd0);
        checkOutput("reset a_req_ready", 32'(a_req_ready), 32'd1);
        checkOutput("reset b_req_ready", 32'(b_req_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single transactions, masks and latency.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Fill the whole array back-to-back, then stream all 16 reads.
        for (int i = 0; i < 16; i++) begin
            a_req_valid = 1; a_req_we = 1; a_req_wmask = 2'b11;
            a_req_addr = 4'(i); a_req_wdata = 16'(i * 32'h1111);
            @(posedge clk); #1;
        end
        a_req_valid = 0; a_req_we = 0;
        rx = 0; gap = 0; notReady = 0;
        for (int c = 0; c < 20; c++) begin
            a_req_valid = (c < 16);
            a_req_addr  = 4'(c);
            @(negedge clk);
            if (c < 16 && !a_req_ready) notReady++;
            if (a_rsp_valid) begin
                checkOutput($sformatf("stream rsp%0d", rx), 32'(a_rsp_rdata), 32'(rx * 32'h1111));
                rx++;
            end else if (rx > 0 && rx < 16) begin
                gap = 1;
            end
            @(posedge clk); #1;
        end
        a_req_valid = 0;
        checkOutput("stream count", 32'(rx), 32'd16);
        checkOutput("stream gap", 32'(gap), 32'd0);
        checkOutput("stream ready low", 32'(notReady), 32'd0);

        // Backpressure: only RSP_DEPTH reads fit while responses are held.
        a_rsp_ready = 0; acc = 0;
        for (int c = 0; c < 10; c++) begin
            a_req_valid = (acc < 6);
            a_req_addr  = 4'(acc);
            @(negedge clk);
            if (a_req_valid && a_req_ready) acc++;
            @(posedge clk); #1;
        end
        checkOutput("bp accepted", 32'(acc), 32'd4);
        a_req_valid = 1; a_req_addr = 4'(acc);
        @(negedge clk);
        checkOutput("bp a_req_ready", 32'(a_req_ready), 32'd0);
        checkOutput("bp a_rsp_valid", 32'(a_rsp_valid), 32'd1);
        holdData = a_rsp_rdata;
        checkOutput("bp head data", 32'(holdData), 32'h0000);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("bp head stable", 32'(a_rsp_rdata), 32'(holdData));
        @(posedge clk); #1;
        a_rsp_ready = 1; rx = 0; early = 0;
        for (int c = 0; c < 20; c++) begin
            a_req_valid = (acc < 6);
            a_req_addr  = 4'(acc);
            @(negedge clk);
            if (a_req_valid && a_req_ready) begin
                if (rx < 1) early++;
                acc++;
            end
            if (a_rsp_valid) begin
                checkOutput($sformatf("bp rsp%0d", rx), 32'(a_rsp_rdata), 32'(rx * 32'h1111));
                rx++;
            end
            @(posedge clk); #1;
        end
        a_req_valid = 0;
        checkOutput("bp total accepted", 32'(acc), 32'd6);
        checkOutput("bp total responses", 32'(rx), 32'd6);
        checkOutput("bp accept before pop", 32'(early), 32'd0);

        // Same-cycle collision: A writes 5, B reads 5.
        a_req_valid = 1; a_req_we = 1; a_req_wmask = 2'b11; a_req_addr = 4'd5; a_req_wdata = 16'h0BAD;
        b_req_valid = 1; b_req_addr = 4'd5;
        @(negedge clk);
        checkOutput("coll a_req_ready", 32'(a_req_ready), 32'd1);
        checkOutput("coll b_req_ready", 32'(b_req_ready), 32'd0);
        @(posedge clk); #1;
        a_req_valid = 0; a_req_we = 0;
        checkOutput("coll csb1 stalled", 32'(csb1), 32'd1);
        @(negedge clk);
        checkOutput("coll b_req_ready next", 32'(b_req_ready), 32'd1);
        @(posedge clk); #1;
        b_req_valid = 0;
        checkOutput("coll csb1 issued", 32'(csb1), 32'd0);
        checkOutput("coll addr1", 32'(addr1), 32'd5);
        waitRsp(1'b1, 16'h0BAD, "coll rspB");

        // Different addresses in the same cycle: no stall.
        a_req_valid = 1; a_req_we = 1; a_req_addr = 4'd6; a_req_wdata = 16'h0600;
        b_req_valid = 1; b_req_addr = 4'd4;
        @(negedge clk);
        checkOutput("nocoll a_req_ready", 32'(a_req_ready), 32'd1);
        checkOutput("nocoll b_req_ready", 32'(b_req_ready), 32'd1);
        @(posedge clk); #1;
        a_req_valid = 0; a_req_we = 0; b_req_valid = 0;
        checkOutput("nocoll csb0", 32'(csb0), 32'd0);
        checkOutput("nocoll csb1", 32'(csb1), 32'd0);
        waitRsp(1'b1, 16'h4444, "nocoll rspB");

        // A write followed immediately by an A read of the same word.
        a_req_valid = 1; a_req_we = 1; a_req_addr = 4'd8; a_req_wdata = 16'h0808;
        @(posedge clk); #1;
        a_req_we = 0;
        @(posedge clk); #1;
        a_req_valid = 0;
        waitRsp(1'b0, 16'h0808, "b2b rspA");

        // Reset with two reads in flight and one buffered.
        a_rsp_ready = 0; b_rsp_ready = 0;
        for (int i = 1; i < 4; i++) begin
            a_req_valid = 1; a_req_addr = 4'(i);
            b_req_valid = (i == 3); b_req_addr = 4'd2;
            @(posedge clk); #1;
        end
        a_req_valid = 0; b_req_valid = 0;
        checkOutput("pre-rst a_rsp_valid", 32'(a_rsp_valid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst csb0", 32'(csb0), 32'd1);
        checkOutput("rst csb1", 32'(csb1), 32'd1);
        checkOutput("rst web0", 32'(web0), 32'd1);
        checkOutput("rst addr0", 32'(addr0), 32'd0);
        checkOutput("rst a_rsp_valid", 32'(a_rsp_valid), 32'd0);
        checkOutput("rst b_rsp_valid", 32'(b_rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        a_rsp_ready = 1; b_rsp_ready = 1; stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (a_rsp_valid || b_rsp_valid) stale++;
            @(posedge clk); #1;
        end
        checkOutput("rst stale responses", 32'(stale), 32'd0);
        a_rsp_ready = 0; b_rsp_ready = 0; accA = 0; accB = 0;
        for (int c = 0; c < 7; c++) begin
            a_req_valid = 1; a_req_addr = 4'(c);
            b_req_valid = 1; b_req_addr = 4'(c);
            @(negedge clk);
            if (a_req_ready) accA++;
            if (b_req_ready) accB++;
            @(posedge clk); #1;
        end
        a_req_valid = 0; b_req_valid = 0;
        checkOutput("rst credits A", 32'(accA), 32'd4);
        checkOutput("rst credits B", 32'(accB), 32'd4);
        a_rsp_ready = 1; b_rsp_ready = 1;
        repeat (8) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
